ninjin_burst_reader: RTL and testbench



---
 rtl/ninjin_pkg.sv | 11 +
 rtl/ninjin_skid_fifo.sv | 36 +++
 rtl/ninjin_burst_reader.sv | 94 +++++++++
 tb/tb_ninjin_burst_reader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ninjin_pkg.sv
// ninjin_pkg: shared ninjin bridge types and default widths
//   PORT_DEF     data word width
//   MEMADDR_DEF  memory address width
//   LENW_DEF     burst length field width
//   ninjin_rd_state_t  burst reader FSM states
package ninjin_pkg;
    localparam int PORT_DEF    = 32;
    localparam int MEMADDR_DEF = 12;
    localparam int LENW_DEF    = 16;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} ninjin_rd_state_t;
endpackage

// File: rtl/ninjin_skid_fifo.sv
// ninjin_skid_fifo: 2-entry FIFO absorbing memory read latency under back-pressure
//   clk, xrst   clock, asynchronous active-low reset
//   push, din   write strobe and word
//   pop         read strobe (head advances)
//   head        oldest stored word
//   count       occupancy 0..2; push and pop together leave it unchanged
module ninjin_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         xrst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wp, rp;
    assign head = mem[rp];
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            mem   <= '{default: '0};
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= !wp;
            end
            if (pop) rp <= !rp;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/ninjin_burst_reader.sv
// ninjin_burst_reader: burst read engine streaming buffer memory words to the host
//   clk, xrst                      clock, asynchronous active-low reset
//   req_valid/req_ready            burst request handshake (ready only when idle)
//   req_addr, req_len              first word address, word count (0 legal)
//   mem_en, mem_addr, mem_rdata    1-cycle-latency memory read port
//   out_valid/out_ready            host stream handshake
//   out_data, out_last             stream word and final-word marker
//   done                           one-cycle pulse at burst completion
module ninjin_burst_reader
    import ninjin_pkg::*;
#(
    parameter int PORT    = PORT_DEF,
    parameter int MEMADDR = MEMADDR_DEF,
    parameter int LENW    = LENW_DEF
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MEMADDR-1:0] req_addr,
    input  logic [LENW-1:0]    req_len,
    output logic               mem_en,
    output logic [MEMADDR-1:0] mem_addr,
    input  logic [PORT-1:0]    mem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PORT-1:0]    out_data,
    output logic               out_last,
    output logic               done
);
    ninjin_rd_state_t state;
    logic [LENW-1:0]    issue_cnt, sent_cnt;
    logic [MEMADDR-1:0] addr;
    logic               rd_pend, rd_last;
    logic [1:0]         count, occ;
    logic [PORT:0]      head, word;
    logic               fire, push, pop;

    ninjin_skid_fifo #(.W(PORT + 1)) u_fifo (
        .clk   (clk),
        .xrst  (xrst),
        .push  (push),
        .pop   (pop),
        .din   ({rd_last, mem_rdata}),
        .head  (head),
        .count (count)
    );

    // The in-flight read counts as occupied so the FIFO can never overflow.
    assign occ       = count + {1'b0, rd_pend};
    assign mem_en    = state == S_READ && issue_cnt != '0 && occ < 2'd2;
    assign mem_addr  = addr;
    assign req_ready = state == S_IDLE;
    assign done      = state == S_DONE;
    // An empty FIFO passes returning read data straight through, giving the
    // two-cycle request-to-data latency; a stalled word is parked in the FIFO.
    assign out_valid = count != 2'd0 || rd_pend;
    assign word      = count != 2'd0 ? head : rd_pend ? {rd_last, mem_rdata} : '0;
    assign out_data  = word[PORT-1:0];
    assign out_last  = out_valid && word[PORT];
    assign fire      = out_valid && out_ready;
    assign pop       = fire && count != 2'd0;
    assign push      = rd_pend && (count != 2'd0 || !out_ready);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
            sent_cnt  <= '0;
            addr      <= '0;
            rd_pend   <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            rd_pend <= mem_en;
            rd_last <= mem_en && issue_cnt == LENW'(1);
            if (mem_en) begin
                addr      <= addr + MEMADDR'(1);
                issue_cnt <= issue_cnt - LENW'(1);
            end
            if (fire) sent_cnt <= sent_cnt - LENW'(1);
            case (state)
                S_IDLE: if (req_valid) begin
                    addr      <= req_addr;
                    issue_cnt <= req_len;
                    sent_cnt  <= req_len;
                    state     <= req_len == '0 ? S_DONE : S_READ;
                end
                S_READ:  if (mem_en && issue_cnt == LENW'(1)) state <= S_DRAIN;
                S_DRAIN: if (sent_cnt == '0 || (fire && sent_cnt == LENW'(1))) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ninjin_burst_reader.sv
// tb_ninjin_burst_reader: directed bench with a queue-based stream model
module tb_ninjin_burst_reader;
    logic        clk = 0, xrst = 0;
    logic        req_valid = 0, req_ready;
    logic [11:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready = 1, out_last, done;
    logic [31:0] out_data;

    ninjin_burst_reader dut (
        .clk(clk), .xrst(xrst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .done(done)
    );

    always #5 clk = !clk;

    function automatic logic [31:0] f(input logic [11:0] a);
        return {a, 4'h0, ~a, 4'h5};
    endfunction

    always @(posedge clk) if (mem_en) mem_rdata <= f(mem_addr);

    int errors = 0, checks = 0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: every accepted burst queues its addresses and {last, word} stream.
    logic [32:0] exp_q[$];
    logic [11:0] addr_q[$], iss_log[$];
    int   cyc = 0, cur, acc = 0, outstanding = 0;
    int   first_en = -1, first_valid = -1, done_off = -1, en_count = 0, fire_count = 0;
    logic busy = 0, exp_done = 0, idle;
    logic [31:0] first_word = '0;

    always @(posedge clk) begin
        cur = cyc;
        cyc = cyc + 1;
        if (!xrst) begin
            exp_q.delete(); addr_q.delete();
            outstanding = 0; busy = 0; exp_done = 0;
        end else begin
            idle = !busy;
            if (exp_done) busy = 0;
            exp_done = 0;
            if (mem_en) begin
                outstanding++; en_count++;
                iss_log.push_back(mem_addr);
                if (first_en < 0) first_en = cur - acc;
                if (addr_q.size() != 0) void'(addr_q.pop_front());
            end
            if (out_valid && first_valid < 0) first_valid = cur - acc;
            if (out_valid && out_ready) begin
                if (fire_count == 0) first_word = out_data;
                fire_count++; outstanding--;
                if (exp_q.size() != 0) begin
                    if (exp_q[0][32]) exp_done = 1;
                    void'(exp_q.pop_front());
                end
            end
            if (done && done_off < 0) done_off = cur - acc;
            if (idle && req_valid) begin
                acc = cur; busy = 1;
                first_en = -1; first_valid = -1; done_off = -1;
                en_count = 0; fire_count = 0; iss_log.delete();
                if (req_len == 0) exp_done = 1;
                for (int i = 0; i < int'(req_len); i++) begin
                    addr_q.push_back(req_addr + 12'(i));
                    exp_q.push_back({i == int'(req_len) - 1, f(req_addr + 12'(i))});
                end
            end
        end
    end

    always @(negedge clk) if (xrst) begin
        chk("done", {31'b0, done}, {31'b0, exp_done});
        chk("req_ready", {31'b0, req_ready}, {31'b0, !busy});
        if (mem_en) begin
            chk("outstanding_lt2", {31'b0, outstanding < 2}, 32'd1);
            chk("mem_en_expected", {31'b0, addr_q.size() != 0}, 32'd1);
            if (addr_q.size() != 0) chk("mem_addr", {20'b0, mem_addr}, {20'b0, addr_q[0]});
        end
        if (out_valid) begin
            chk("out_valid_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q[0][31:0]);
                chk("out_last", {31'b0, out_last}, {31'b0, exp_q[0][32]});
            end
        end else chk("out_last_idle", {31'b0, out_last}, 32'd0);
    end

    task automatic req(input logic [11:0] a, input logic [15:0] l);
        @(posedge clk); #1;
        req_valid = 1; req_addr = a; req_len = l;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    logic [3:0] pat = 4'b1001;
    task automatic run_until_done(input int budget, input bit tog);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = done;
            if (!seen) begin
                @(posedge clk); #1;
                if (tog) out_ready = pat[i % 4];
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        @(posedge clk); #1;
        out_ready = 1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        #2;
        chk_reset_outputs();
        @(posedge clk); @(posedge clk); #1;
        xrst = 1;

        // burst 0x010 x4 at full rate
        req(12'h010, 16'd4);
        run_until_done(30, 0);
        chk("b1_first_en_off", first_en, 1);
        chk("b1_first_valid_off", first_valid, 2);
        chk("b1_done_off", done_off, 6);
        chk("b1_en_count", en_count, 4);
        chk("b1_first_word", first_word, 32'h0100FEF5);
        chk("b1_addr3", {20'b0, iss_log[3]}, 32'h013);

        // zero-length burst
        req(12'h055, 16'd0);
        run_until_done(10, 0);
        chk("b2_done_off", done_off, 1);
        chk("b2_en_count", en_count, 0);
        chk("b2_valid_never", first_valid, -1);

        // address wrap
        req(12'hFFE, 16'd4);
        run_until_done(30, 0);
        chk("b3_addr0", {20'b0, iss_log[0]}, 32'hFFE);
        chk("b3_addr1", {20'b0, iss_log[1]}, 32'hFFF);
        chk("b3_addr2", {20'b0, iss_log[2]}, 32'h000);
        chk("b3_addr3", {20'b0, iss_log[3]}, 32'h001);
        chk("b3_first_word", first_word, 32'hFFE00015);

        // toggling back-pressure
        req(12'h200, 16'd8);
        run_until_done(80, 1);
        chk("b4_fire_count", fire_count, 8);
        chk("b4_en_count", en_count, 8);

        // long stall
        out_ready = 0;
        req(12'h300, 16'd5);
        repeat (20) @(posedge clk);
        #1;
        chk("b5_stall_en_count", en_count, 2);
        chk("b5_stall_fire_count", fire_count, 0);
        out_ready = 1;
        run_until_done(30, 0);
        chk("b5_fire_count", fire_count, 5);

        // reset mid-burst, then a fresh burst
        req(12'h400, 16'd6);
        for (int i = 0; i < 40 && fire_count < 2; i++) @(negedge clk);
        chk("b6_reached_word3", fire_count, 2);
        #1 xrst = 0;
        #1 chk_reset_outputs();
        @(posedge clk); @(posedge clk); #1;
        xrst = 1;
        req(12'h100, 16'd2);
        run_until_done(20, 0);
        chk("b7_done_off", done_off, 4);
        chk("b7_fire_count", fire_count, 2);
        chk("b7_first_word", first_word, 32'h1000EFF5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
